// File: rtl/mode_edit_ctrl.sv
// ChronoFlex UI sequencer: button debounce, mode FSM, clock-edit and countdown-timer buffers.
// Every output is a register; the digit outputs are loaded from the same next values as the buffers.
module mode_edit_ctrl #(
   parameter int DB_COUNT = 1_000_000,
   parameter int TICK_DIV = 100_000_000
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_sel,
   input  logic       btn_inc,
   input  logic       btn_start,
   input  logic [3:0] time_ones,
   input  logic [3:0] time_tens,
   input  logic [3:0] time_hundreds,
   input  logic [3:0] time_thousands,
   output logic [1:0] state,
   output logic       tm_state,
   output logic       edit_place,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] hundreds,
   output logic [3:0] thousands,
   output logic       time_load,
   output logic [7:0] set_hh,
   output logic [7:0] set_mm,
   output logic       timer_done
);

   // state     | meaning
   // ----------+----------------------------------------------
   // S_CLOCK   | show live time; mode copies it into the edit buffer
   // S_SET     | edit clock buffer HH:MM; mode loads it into the timekeeper
   // S_TIMER   | edit / run the MM:SS countdown
   // S_BAD     | unreachable; recovers to S_CLOCK
   typedef enum logic [1:0] {S_CLOCK = 2'd0, S_SET = 2'd1, S_TIMER = 2'd2, S_BAD = 2'd3} state_t;

   localparam int DW = $clog2(DB_COUNT + 1);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_t st, st_n;

   logic [3:0]    raw, sync1, sync2, db, db_d, press;
   logic [DW-1:0] db_cnt [4];
   logic          ev_mode, ev_start, ev_sel, ev_inc;

   logic          ep, ep_n, tm, tm_n, load, load_n, done, done_n;
   logic [7:0]    clk_hh, clk_hh_n, clk_mm, clk_mm_n;
   logic [7:0]    tmr_mm, tmr_mm_n, tmr_ss, tmr_ss_n;
   logic [15:0]   dig, dig_n, dec_val;
   logic [TW-1:0] tick_cnt, tick_cnt_n;
   logic          tick;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max)           return 8'h00;
      else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                     return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                return {v[7:4], v[3:0] - 4'd1};
   endfunction

   assign raw = {btn_mode, btn_start, btn_sel, btn_inc};

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         db_d  <= '0;
         press <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         db_d  <= db;
         press <= db & ~db_d;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DW'(DB_COUNT)) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // mode > start > sel > inc; losers in the same cycle are discarded
   assign ev_mode  = press[3];
   assign ev_start = press[2] & ~press[3];
   assign ev_sel   = press[1] & ~(|press[3:2]);
   assign ev_inc   = press[0] & ~(|press[3:1]);

   assign tick    = tm && (tick_cnt == TW'(TICK_DIV - 1));
   assign dec_val = (tmr_ss == 8'h00) ? {bcd_dec(tmr_mm), 8'h59} : {tmr_mm, bcd_dec(tmr_ss)};

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) st <= S_CLOCK;
      else       st <= st_n;
   end

   always_comb begin
      st_n = st;
      case (st)
         S_CLOCK: if (ev_mode) st_n = S_SET;
         S_SET:   if (ev_mode) st_n = S_TIMER;
         S_TIMER: if (ev_mode) st_n = S_CLOCK;
         default: st_n = S_CLOCK;
      endcase
   end

   always_comb begin
      ep_n     = ep;
      tm_n     = tm;
      load_n   = 1'b0;
      done_n   = 1'b0;
      clk_hh_n = clk_hh;
      clk_mm_n = clk_mm;
      tmr_mm_n = tmr_mm;
      tmr_ss_n = tmr_ss;
      case (st)
         S_CLOCK: begin
            if (ev_mode) begin
               clk_hh_n = {time_thousands, time_hundreds};
               clk_mm_n = {time_tens, time_ones};
               ep_n     = 1'b1;
            end
         end
         S_SET: begin
            if (ev_mode) begin
               load_n = 1'b1;
               tm_n   = 1'b0;
               ep_n   = 1'b1;
            end else if (ev_sel) begin
               ep_n = ~ep;
            end else if (ev_inc) begin
               if (ep) clk_hh_n = bcd_inc(clk_hh, 8'h23);
               else    clk_mm_n = bcd_inc(clk_mm, 8'h59);
            end
         end
         S_TIMER: begin
            if (ev_mode) begin
               tm_n = 1'b0;
               ep_n = 1'b0;
            end else if (!tm) begin
               if (ev_sel) begin
                  ep_n = ~ep;
               end else if (ev_inc) begin
                  if (ep) tmr_mm_n = bcd_inc(tmr_mm, 8'h59);
                  else    tmr_ss_n = bcd_inc(tmr_ss, 8'h59);
               end else if (ev_start && ({tmr_mm, tmr_ss} != 16'h0000)) begin
                  tm_n = 1'b1;
               end
            end else begin
               // a pause landing on a tick edge suppresses that decrement
               if (ev_start) begin
                  tm_n = 1'b0;
               end else if (tick) begin
                  {tmr_mm_n, tmr_ss_n} = dec_val;
                  if (dec_val == 16'h0000) begin
                     tm_n   = 1'b0;
                     done_n = 1'b1;
                  end
               end
            end
         end
         default: begin
            tm_n = 1'b0;
            ep_n = 1'b0;
         end
      endcase

      if (!tm || !tm_n || tick) tick_cnt_n = '0;
      else                      tick_cnt_n = tick_cnt + 1'b1;

      case (st_n)
         S_SET:   dig_n = {clk_hh_n, clk_mm_n};
         S_TIMER: dig_n = {tmr_mm_n, tmr_ss_n};
         default: dig_n = {time_thousands, time_hundreds, time_tens, time_ones};
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         ep       <= 1'b0;
         tm       <= 1'b0;
         load     <= 1'b0;
         done     <= 1'b0;
         clk_hh   <= 8'h00;
         clk_mm   <= 8'h00;
         tmr_mm   <= 8'h00;
         tmr_ss   <= 8'h00;
         tick_cnt <= '0;
         dig      <= 16'h0000;
      end else begin
         ep       <= ep_n;
         tm       <= tm_n;
         load     <= load_n;
         done     <= done_n;
         clk_hh   <= clk_hh_n;
         clk_mm   <= clk_mm_n;
         tmr_mm   <= tmr_mm_n;
         tmr_ss   <= tmr_ss_n;
         tick_cnt <= tick_cnt_n;
         dig      <= dig_n;
      end
   end

   assign state      = st;
   assign tm_state   = tm;
   assign edit_place = ep;
   assign time_load  = load;
   assign timer_done = done;
   assign set_hh     = clk_hh;
   assign set_mm     = clk_mm;
   assign thousands  = dig[15:12];
   assign hundreds   = dig[11:8];
   assign tens       = dig[7:4];
   assign ones       = dig[3:0];

endmodule

// File: tb/tb_mode_edit_ctrl.sv
// Directed bench for mode_edit_ctrl with a scoreboard queue of expected snapshots.
module tb_mode_edit_ctrl;
   localparam int DB = 4;
   localparam int TK = 10;
   localparam logic [3:0] B_MODE  = 4'b1000;
   localparam logic [3:0] B_START = 4'b0100;
   localparam logic [3:0] B_SEL   = 4'b0010;
   localparam logic [3:0] B_INC   = 4'b0001;

   logic       clk_100MHz = 1'b0;
   logic       reset = 1'b1;
   logic       btn_mode = 1'b0, btn_sel = 1'b0, btn_inc = 1'b0, btn_start = 1'b0;
   logic [3:0] time_ones, time_tens, time_hundreds, time_thousands;
   logic [1:0] state;
   logic       tm_state, edit_place, time_load, timer_done;
   logic [3:0] ones, tens, hundreds, thousands;
   logic [7:0] set_hh, set_mm;

   int errors = 0;
   int checks = 0;
   int n_load = 0;
   int n_done = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   mode_edit_ctrl #(.DB_COUNT(DB), .TICK_DIV(TK)) dut (
      .clk_100MHz(clk_100MHz), .reset(reset),
      .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_inc(btn_inc), .btn_start(btn_start),
      .time_ones(time_ones), .time_tens(time_tens),
      .time_hundreds(time_hundreds), .time_thousands(time_thousands),
      .state(state), .tm_state(tm_state), .edit_place(edit_place),
      .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
      .time_load(time_load), .set_hh(set_hh), .set_mm(set_mm), .timer_done(timer_done)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   always @(negedge clk_100MHz) begin
      if (time_load)  n_load = n_load + 1;
      if (timer_done) n_done = n_done + 1;
   end

   function automatic logic [31:0] snap();
      return {12'd0, state, tm_state, edit_place, thousands, hundreds, tens, ones};
   endfunction

   function automatic logic [31:0] mk(input logic [1:0] s, input logic t, input logic e,
                                      input logic [15:0] d);
      return {12'd0, s, t, e, d};
   endfunction

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check_val(input logic [31:0] obs);
      logic [31:0] e;
      string t;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_100MHz);
      #1;
   endtask

   task automatic drive(input logic [3:0] m);
      {btn_mode, btn_start, btn_sel, btn_inc} = m;
   endtask

   // raw rises just after an edge; the resulting output change is on the (DB+5)th edge
   task automatic press(input logic [3:0] m);
      drive(m);
      cyc(DB + 5);
   endtask

   task automatic release_all();
      drive(4'b0000);
      cyc(DB + 6);
   endtask

   task automatic set_live(input logic [15:0] v);
      {time_thousands, time_hundreds, time_tens, time_ones} = v;
   endtask

   initial begin
      set_live(16'h1234);
      cyc(3);
      reset = 1'b0;
      cyc(1);
      expect_val("reset_state", mk(2'd0, 1'b0, 1'b0, 16'h1234));
      check_val(snap());
      expect_val("reset_pulses", 32'd0);
      check_val({30'd0, time_load, timer_done});

      btn_mode = 1'b1;
      cyc(3);
      btn_mode = 1'b0;
      expect_val("glitch", mk(2'd0, 1'b0, 1'b0, 16'h1234));
      cyc(12);
      check_val(snap());

      set_live(16'h2359);
      expect_val("live_follow", mk(2'd0, 1'b0, 1'b0, 16'h2359));
      cyc(1);
      check_val(snap());

      expect_val("db_early", mk(2'd0, 1'b0, 1'b0, 16'h2359));
      expect_val("db_press", mk(2'd1, 1'b0, 1'b1, 16'h2359));
      btn_mode = 1'b1;
      cyc(DB + 4);
      check_val(snap());
      cyc(1);
      check_val(snap());
      release_all();

      expect_val("hour_wrap", mk(2'd1, 1'b0, 1'b1, 16'h0059));
      press(B_INC); check_val(snap()); release_all();
      expect_val("sel_toggle", mk(2'd1, 1'b0, 1'b0, 16'h0059));
      press(B_SEL); check_val(snap()); release_all();
      expect_val("min_wrap", mk(2'd1, 1'b0, 1'b0, 16'h0000));
      press(B_INC); check_val(snap()); release_all();

      expect_val("enter_timer", mk(2'd2, 1'b0, 1'b1, 16'h0000));
      expect_val("load_pulse", {15'd0, 1'b1, 16'h0000});
      press(B_MODE);
      check_val(snap());
      check_val({15'd0, time_load, set_hh, set_mm});
      expect_val("load_one_cycle", 32'd0);
      cyc(1);
      check_val({31'd0, time_load});
      release_all();

      expect_val("tmr_min_inc", mk(2'd2, 1'b0, 1'b1, 16'h0100));
      press(B_INC); check_val(snap()); release_all();

      // countdown 01:00 -> 00:00 over 60 ticks
      expect_val("start", mk(2'd2, 1'b1, 1'b1, 16'h0100));
      press(B_START); check_val(snap());
      drive(4'b0000);
      expect_val("pre_first_tick", mk(2'd2, 1'b1, 1'b1, 16'h0100));
      cyc(TK - 1); check_val(snap());
      expect_val("first_tick", mk(2'd2, 1'b1, 1'b1, 16'h0059));
      cyc(1); check_val(snap());
      expect_val("tens_borrow", mk(2'd2, 1'b1, 1'b1, 16'h0049));
      cyc(10 * TK); check_val(snap());
      expect_val("pre_zero", mk(2'd2, 1'b1, 1'b1, 16'h0001));
      cyc(49 * TK - 1); check_val(snap());
      expect_val("zero", mk(2'd2, 1'b0, 1'b1, 16'h0000));
      expect_val("done_pulse", 32'd1);
      cyc(1);
      check_val(snap());
      check_val({31'd0, timer_done});
      expect_val("done_one_cycle", 32'd0);
      cyc(1); check_val({31'd0, timer_done});

      expect_val("zero_start", mk(2'd2, 1'b0, 1'b1, 16'h0000));
      press(B_START); check_val(snap()); release_all();

      // pause / resume
      expect_val("tmr_reload", mk(2'd2, 1'b0, 1'b1, 16'h0100));
      press(B_INC); check_val(snap()); release_all();
      expect_val("start2", mk(2'd2, 1'b1, 1'b1, 16'h0100));
      press(B_START); check_val(snap());
      drive(4'b0000);
      expect_val("run_57", mk(2'd2, 1'b1, 1'b1, 16'h0057));
      cyc(3 * TK); check_val(snap());
      expect_val("pause", mk(2'd2, 1'b0, 1'b1, 16'h0057));
      press(B_START); check_val(snap());
      release_all();
      expect_val("pause_hold", mk(2'd2, 1'b0, 1'b1, 16'h0057));
      cyc(40); check_val(snap());

      expect_val("resume", mk(2'd2, 1'b1, 1'b1, 16'h0057));
      press(B_START); check_val(snap());
      drive(4'b0000);
      expect_val("resume_pre", mk(2'd2, 1'b1, 1'b1, 16'h0057));
      cyc(TK - 1); check_val(snap());
      expect_val("resume_tick", mk(2'd2, 1'b1, 1'b1, 16'h0056));
      cyc(1); check_val(snap());
      // pause press lands exactly on the next tick edge
      cyc(1);
      expect_val("start_vs_tick", mk(2'd2, 1'b0, 1'b1, 16'h0056));
      press(B_START); check_val(snap());
      release_all();

      expect_val("resume2", mk(2'd2, 1'b1, 1'b1, 16'h0056));
      press(B_START); check_val(snap());
      drive(4'b0000);
      expect_val("run_42", mk(2'd2, 1'b1, 1'b1, 16'h0042));
      cyc(14 * TK); check_val(snap());
      expect_val("pause_42", mk(2'd2, 1'b0, 1'b1, 16'h0042));
      press(B_START); check_val(snap());
      release_all();

      // retention across a full mode cycle, and mode+inc together
      expect_val("to_clock", mk(2'd0, 1'b0, 1'b0, 16'h2359));
      press(B_MODE); check_val(snap()); release_all();
      expect_val("to_set", mk(2'd1, 1'b0, 1'b1, 16'h2359));
      press(B_MODE); check_val(snap()); release_all();
      expect_val("simul_mode_inc", mk(2'd2, 1'b0, 1'b1, 16'h0042));
      expect_val("simul_load", {15'd0, 1'b1, 16'h2359});
      press(B_MODE | B_INC);
      check_val(snap());
      check_val({15'd0, time_load, set_hh, set_mm});
      release_all();

      expect_val("tmr_sel", mk(2'd2, 1'b0, 1'b0, 16'h0042));
      press(B_SEL); check_val(snap()); release_all();
      expect_val("tmr_sec_inc", mk(2'd2, 1'b0, 1'b0, 16'h0043));
      press(B_INC); check_val(snap()); release_all();

      // reset while counting down
      expect_val("start3", mk(2'd2, 1'b1, 1'b0, 16'h0043));
      press(B_START); check_val(snap());
      drive(4'b0000);
      cyc(2 * TK);
      reset = 1'b1;
      #1;
      expect_val("reset_async", mk(2'd0, 1'b0, 1'b0, 16'h0000));
      check_val(snap());
      cyc(2);
      reset = 1'b0;
      expect_val("reset_live", mk(2'd0, 1'b0, 1'b0, 16'h2359));
      cyc(1); check_val(snap());
      cyc(20);

      expect_val("tmr_buf_set", mk(2'd1, 1'b0, 1'b1, 16'h2359));
      press(B_MODE); check_val(snap()); release_all();
      expect_val("tmr_buf_reset", mk(2'd2, 1'b0, 1'b1, 16'h0000));
      press(B_MODE); check_val(snap()); release_all();

      expect_val("load_count", 32'd3);
      check_val(32'(n_load));
      expect_val("done_count", 32'd1);
      check_val(32'(n_done));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mode_edit_ctrl.md
# mode_edit_ctrl

User-interface sequencer for the ChronoFlex timekeeper. It debounces four push-buttons and runs the mode state machine (clock / set-clock / timer). It owns the clock-edit and countdown-timer buffers, and drives the 4-digit BCD value plus the `state`, `tm_state` and `edit_place` controls into the seven-segment display driver. It also issues the one-cycle load pulse that writes an edited time back into the timekeeper counter.

## Interface
- `DB_COUNT`, default 1_000_000: cycles a synchronized button level must stay stable before it is accepted (10 ms).
- `TICK_DIV`, default 100_000_000: cycles per timer decrement (1 s).
- `clk_100MHz`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `btn_mode`, `btn_sel`, `btn_inc`, `btn_start`, in, 1 each: raw asynchronous buttons, active-high.
- `time_ones`, `time_tens`, `time_hundreds`, `time_thousands`, in, 4 each: live clock in BCD; thousands/hundreds = hours H:h, tens/ones = minutes M:m.
- `state`, out, 2: 0 CLOCK, 1 SET_CLOCK, 2 TIMER.
- `tm_state`, out, 1: 0 timer set/paused, 1 running.
- `edit_place`, out, 1: 1 = upper pair (thousands/hundreds), 0 = lower pair.
- `ones`, `tens`, `hundreds`, `thousands`, out, 4 each: BCD digits to the display.
- `time_load`, out, 1: one-cycle pulse; the load value is on `set_hh` and `set_mm`.
- `set_hh`, `set_mm`, out, 8 each: BCD {tens, ones} of the clock edit buffer.
- `timer_done`, out, 1: one-cycle pulse when the countdown reaches 00:00.

## Operation
- **Button path (per button)**
  - 2-FF synchronizer.
  - Counter clears while the synchronized value equals the debounced level, and counts while they differ.
  - On reaching `DB_COUNT` the debounced level takes the synchronized value.
  - Rising edge of the debounced level gives a one-cycle press pulse.
- **Simultaneous pulses:** priority is mode > start > sel > inc. Lower-priority pulses in the same cycle are dropped.
- **CLOCK (0):** digits = live time inputs.
  - mode: copy the live time into the clock edit buffer, set `edit_place`=1, go to SET_CLOCK.
  - sel, inc, start: ignored.
- **SET_CLOCK (1):** digits = clock edit buffer.
  - sel: toggle `edit_place`.
  - inc: `edit_place`=1 increments hours 00..23, wrapping 23→00. `edit_place`=0 increments minutes 00..59, wrapping 59→00. The other field is unchanged; BCD is carried within the field.
  - mode: pulse `time_load` for one cycle with `set_hh`/`set_mm` = buffer, then go to TIMER with `tm_state`=0 and `edit_place`=1.
  - start: ignored.
- **TIMER (2):** digits = timer buffer MM:SS (thousands/hundreds = minutes).
  - `tm_state`=0:
    - sel toggles `edit_place`.
    - inc increments minutes (`edit_place`=1) or seconds (`edit_place`=0), each 00..59 with wrap.
    - start sets `tm_state`=1 only if the buffer ≠ 00:00.
  - `tm_state`=1:
    - each tick decrements MM:SS as BCD (seconds 00 borrows → 59 and minutes −1).
    - On the decrement that reaches 00:00: `tm_state`←0 and `timer_done` pulses in the same cycle.
    - start pauses (`tm_state`←0, value kept).
    - sel and inc are ignored.
  - mode: `tm_state`←0, `edit_place`←0, go to CLOCK. The timer buffer is retained.
- **State value 3:** unreachable; if entered, next cycle goes to CLOCK.
- **Buffers:** the timer buffer persists across mode cycles until reset. The clock buffer is overwritten on each entry to SET_CLOCK.

## Timing
- All outputs are registered.
- **Reset values:** `state`=0, `tm_state`=0, `edit_place`=0, both buffers 00:00, tick counter 0, `time_load`=0, `timer_done`=0. Digit outputs equal the live inputs from the first cycle after reset deasserts.
- Reset mid-countdown aborts the countdown with no `timer_done`.
- **Button latency:** a raw input held high from sampled edge 0 gives a press pulse at edge `DB_COUNT`+3. The resulting output change appears at edge `DB_COUNT`+4.
  - Glitches shorter than `DB_COUNT` cycles produce no pulse.
  - Release is debounced identically and produces no pulse.
- **Tick counter:**
  - Range 0..`TICK_DIV`−1.
  - Held at 0 whenever `tm_state`=0.
  - First decrement occurs `TICK_DIV` cycles after `tm_state` rises, then every `TICK_DIV` cycles.
  - Pause and resume restart the full period.
- **Start and tick in the same cycle:** the start (pause) wins and there is no decrement.
- `time_load` and `timer_done` are each high for exactly one cycle per event.

## Test plan
All scenarios use `DB_COUNT`=4 and `TICK_DIV`=10.
- **Reset:** assert reset mid-run with live time 12:34 → `state`=0, `tm_state`=0, `edit_place`=0, digits show 1,2,3,4. No pulses.
- **Debounce:** a 3-cycle glitch on `btn_mode` → no state change. A held press → `state`=1 exactly `DB_COUNT`+4 edges after the press.
- **Clock edit wrap:** live 23:59, mode, inc (hours) → 00:59. Then sel, inc → 00:00. Then mode → `time_load` one cycle with `set_hh`=8'h00, `set_mm`=8'h00, `state`=2.
- **Countdown:** timer set 01:00, start → 00:59 after 10 cycles, …, 00:00 after 600 cycles with `timer_done` and `tm_state`→0 in the same cycle.
- **Pause/resume and zero start:** pause at 00:57, wait 50 cycles → 00:57 held. Resume → 00:56 exactly 10 cycles later. Start at 00:00 → `tm_state` stays 0.
- **Simultaneous and retention:** mode+inc pressed together in SET_CLOCK → only the mode action. Leaving TIMER at 00:42 paused and returning via CLOCK→SET_CLOCK→TIMER → 00:42, `tm_state`=0.
